// File: rtl/countdown_ctrl_if.sv
// Control/status bundle for countdown_ctrl: button/switch/load inputs in,
// count display, tick/done pulses and state out.
interface countdown_ctrl_if #(
    parameter int CW = 8
);
    logic          start;
    logic          sw;
    logic          clr;
    logic [CW-1:0] load_val;
    logic [CW-1:0] count;
    logic          tick;
    logic          done;
    logic [1:0]    state;
    logic          running;

    modport master (
        output start, sw, clr, load_val,
        input  count, tick, done, state, running
    );

    modport slave (
        input  start, sw, clr, load_val,
        output count, tick, done, state, running
    );
endinterface

// File: rtl/countdown_ctrl.sv
// Seconds-tick countdown sequencer: prescaler plus IDLE/RUN/PAUSE/DONE FSM
// that decrements a loaded count once every DIV running cycles.
module countdown_ctrl #(
    parameter int DIV = 125000000,
    parameter int PW  = 27,
    parameter int CW  = 8
) (
    input logic              clk,
    input logic              rst,
    countdown_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q;
    logic [PW-1:0] presc;
    logic [CW-1:0] count_q;
    logic          tick_q;
    logic          done_q;
    logic          running_q;
    logic          start_q;
    logic          start_edge;

    // start_q resets high so a button held through reset release is not an edge
    assign start_edge = bus.start & ~start_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            presc     <= '0;
            count_q   <= '0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
            start_q   <= 1'b1;
        end else begin
            start_q <= bus.start;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
            if (bus.clr) begin
                state_q   <= IDLE;
                running_q <= 1'b0;
                count_q   <= '0;
                presc     <= '0;
            end else if (start_edge) begin
                count_q <= bus.load_val;
                presc   <= '0;
                if (bus.load_val == '0) begin
                    state_q   <= DONE;
                    running_q <= 1'b0;
                    done_q    <= 1'b1;
                end else if (bus.sw) begin
                    state_q   <= PAUSE;
                    running_q <= 1'b0;
                end else begin
                    state_q   <= RUN;
                    running_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    RUN: begin
                        // a pause in the terminal-count cycle defers the tick; presc stays at DIV-1
                        if (bus.sw) begin
                            state_q   <= PAUSE;
                            running_q <= 1'b0;
                        end else if (presc == PW'(DIV - 1)) begin
                            presc <= '0;
                            if (count_q != '0) begin
                                tick_q  <= 1'b1;
                                count_q <= count_q - CW'(1);
                                if (count_q == CW'(1)) begin
                                    state_q   <= DONE;
                                    running_q <= 1'b0;
                                    done_q    <= 1'b1;
                                end
                            end
                        end else begin
                            presc <= presc + PW'(1);
                        end
                    end
                    PAUSE: begin
                        if (!bus.sw) begin
                            state_q   <= RUN;
                            running_q <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.count   = count_q;
    assign bus.tick    = tick_q;
    assign bus.done    = done_q;
    assign bus.state   = state_q;
    assign bus.running = running_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Scoreboard bench for countdown_ctrl at DIV=4: a reference model queues the
// expected outputs per cycle, plus directed timing checks from the test plan.
`timescale 1ns/1ps
module tb_countdown_ctrl;

    localparam int DIV = 4;
    localparam int PW  = 3;
    localparam int CW  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    countdown_ctrl_if #(.CW(CW)) bus ();

    countdown_ctrl #(.DIV(DIV), .PW(PW), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] count;
        logic       tick;
        logic       done;
        logic [1:0] state;
        logic       running;
    } exp_t;

    exp_t expQ[$];

    int checkCount = 0;
    int passCount  = 0;

    int m_state, m_count, m_presc;
    bit m_startq, m_tick, m_done;

    int tickMask, doneMask, tickSeen, tickIdx;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    endtask

    task automatic modelReset();
        m_state = 0; m_count = 0; m_presc = 0;
        m_startq = 1'b1; m_tick = 1'b0; m_done = 1'b0;
        expQ.delete();
    endtask

    task automatic modelStep(input bit st, input bit s, input bit c, input int lv);
        bit isEdge;
        isEdge   = st && !m_startq;
        m_startq = st;
        m_tick   = 1'b0;
        m_done   = 1'b0;
        if (c) begin
            m_state = 0; m_count = 0; m_presc = 0;
        end else if (isEdge) begin
            m_count = lv;
            m_presc = 0;
            if (lv == 0) begin m_state = 3; m_done = 1'b1; end
            else m_state = s ? 2 : 1;
        end else if (m_state == 1) begin
            if (s) m_state = 2;
            else if (m_presc == DIV - 1) begin
                m_presc = 0;
                m_tick  = 1'b1;
                m_count = m_count - 1;
                if (m_count == 0) begin m_state = 3; m_done = 1'b1; end
            end else m_presc = m_presc + 1;
        end else if (m_state == 2 && !s) begin
            m_state = 1;
        end
    endtask

    task automatic applyStimulus(input bit st, input bit s, input bit c, input int lv);
        exp_t e;
        bus.start    = st;
        bus.sw       = s;
        bus.clr      = c;
        bus.load_val = 8'(lv);
        modelStep(st, s, c, lv);
        e.count   = 8'(m_count);
        e.tick    = m_tick;
        e.done    = m_done;
        e.state   = 2'(m_state);
        e.running = (m_state == 1);
        expQ.push_back(e);
        @(posedge clk);
        #1;
        if (expQ.size() == 0) begin
            checkOutput("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = expQ.pop_front();
            checkOutput("count",   32'(bus.count),   32'(e.count));
            checkOutput("tick",    32'(bus.tick),    32'(e.tick));
            checkOutput("done",    32'(bus.done),    32'(e.done));
            checkOutput("state",   32'(bus.state),   32'(e.state));
            checkOutput("running", 32'(bus.running), 32'(e.running));
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_count"},   32'(bus.count),   32'd0);
        checkOutput({tag, "_tick"},    32'(bus.tick),    32'd0);
        checkOutput({tag, "_done"},    32'(bus.done),    32'd0);
        checkOutput({tag, "_state"},   32'(bus.state),   32'd0);
        checkOutput({tag, "_running"}, 32'(bus.running), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.start = 1'b0; bus.sw = 1'b0; bus.clr = 1'b0; bus.load_val = '0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst = 1'b0;

        // basic countdown of 3: ticks 4, 8, 12 cycles after the start edge
        $display("[TB] countdown from 3");
        applyStimulus(0, 0, 0, 3);
        applyStimulus(1, 0, 0, 3);
        checkOutput("t1_start_count", 32'(bus.count), 32'd3);
        tickMask = 0; doneMask = 0;
        for (int i = 1; i <= 13; i++) begin
            applyStimulus(1, 0, 0, 3);
            if (bus.tick) tickMask |= (1 << i);
            if (bus.done) doneMask |= (1 << i);
        end
        checkOutput("t1_tick_cycles", 32'(tickMask), 32'((1 << 4) | (1 << 8) | (1 << 12)));
        checkOutput("t1_done_cycle",  32'(doneMask), 32'(1 << 12));
        checkOutput("t1_final_state", 32'(bus.state), 32'd3);
        checkOutput("t1_final_count", 32'(bus.count), 32'd0);

        // pause after two running cycles, no ticks while paused
        $display("[TB] pause mid-interval");
        applyStimulus(0, 0, 0, 5);
        applyStimulus(1, 0, 0, 5);
        applyStimulus(0, 0, 0, 5);
        applyStimulus(0, 0, 0, 5);
        tickSeen = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 0, 5);
            if (bus.tick) tickSeen++;
        end
        checkOutput("t2_pause_ticks", 32'(tickSeen), 32'd0);
        checkOutput("t2_pause_state", 32'(bus.state), 32'd2);
        tickIdx = 0;
        for (int j = 1; j <= 8 && tickIdx == 0; j++) begin
            applyStimulus(0, 0, 0, 5);
            if (bus.tick) tickIdx = j;
        end
        checkOutput("t2_resume_tick_idx", 32'(tickIdx), 32'd3);
        checkOutput("t2_count_after", 32'(bus.count), 32'd4);

        // restart while running at count 2
        $display("[TB] restart while running");
        repeat (8) applyStimulus(0, 0, 0, 7);
        checkOutput("t3_count_before", 32'(bus.count), 32'd2);
        applyStimulus(1, 0, 0, 7);
        checkOutput("t3_restart_count", 32'(bus.count), 32'd7);
        checkOutput("t3_restart_state", 32'(bus.state), 32'd1);
        tickMask = 0;
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(0, 0, 0, 7);
            if (bus.tick) tickMask |= (1 << i);
        end
        checkOutput("t3_tick_cycle", 32'(tickMask), 32'(1 << 4));
        checkOutput("t3_count_after", 32'(bus.count), 32'd6);

        // start held through reset release gives no edge; then load 0
        $display("[TB] start held through reset, then zero load");
        bus.start = 1'b1;
        rst = 1'b1;
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) applyStimulus(1, 0, 0, 9);
        checkOutput("t4_held_state", 32'(bus.state), 32'd0);
        checkOutput("t4_held_count", 32'(bus.count), 32'd0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("t4_zero_done",  32'(bus.done),  32'd1);
        checkOutput("t4_zero_tick",  32'(bus.tick),  32'd0);
        checkOutput("t4_zero_state", 32'(bus.state), 32'd3);
        applyStimulus(1, 0, 0, 0);
        checkOutput("t4_done_pulse_end", 32'(bus.done), 32'd0);

        // clr beats a simultaneous start edge during RUN
        $display("[TB] clear versus start, async reset");
        applyStimulus(0, 0, 0, 6);
        applyStimulus(1, 0, 0, 6);
        applyStimulus(0, 0, 0, 6);
        applyStimulus(0, 0, 0, 6);
        applyStimulus(1, 0, 1, 9);
        checkAllZero("t5_clr");
        applyStimulus(0, 0, 0, 6);
        applyStimulus(1, 0, 0, 6);
        applyStimulus(0, 0, 0, 6);
        checkOutput("t5_prerst_running", 32'(bus.running), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkAllZero("t5_async_rst");
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(0, 0, 0, 6);
        checkOutput("t5_after_rst_state", 32'(bus.state), 32'd0);

        // pause exactly on the terminal-count cycle defers the tick
        $display("[TB] pause on terminal count");
        applyStimulus(1, 0, 0, 3);
        tickMask = 0;
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1, (i >= 4 && i <= 6), 0, 3);
            if (bus.tick) tickMask |= (1 << i);
        end
        checkOutput("t6_tick_cycle", 32'(tickMask), 32'(1 << 8));
        checkOutput("t6_count_after", 32'(bus.count), 32'd2);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
